// File: rtl/u_rcs32_iter_if.sv
// Purpose: operand/result handshake bundle for u_rcs32_iter (input pair + 33-bit result).
// Latency: none, signal container only.
// Backpressure: in_ready/out_ready gate the two valid/ready handshakes.
// Signals: in_valid/in_ready/a/b (operand side), out_valid/out_ready/u_rcs32_iter_out (result side).
// slave modport is the subtractor's view; master modport is the producer/consumer view.
interface u_rcs32_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] u_rcs32_iter_out;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output u_rcs32_iter_out
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  u_rcs32_iter_out
    );
endinterface

// File: rtl/u_rcs32_iter.sv
// Purpose: iterative unsigned 32-bit subtractor, a - b computed CHUNK bits per cycle with a registered borrow.
// Latency: result valid N = 32/CHUNK cycles after operand acceptance; one op per N+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk, rst (async, active-high), bus (u_rcs32_iter_if.slave: in_valid/in_ready/a/b,
//        out_valid/out_ready/u_rcs32_iter_out[32:0] = {borrow, difference}).
// Build option: define U_RCS32_ITER_SAT_EN to clamp the difference to 0 when a < b.
module u_rcs32_iter #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    u_rcs32_iter_if.slave    bus
);
    localparam int N  = 32 / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_work;
    logic            r_borrow;
    logic [CW-1:0]   r_cnt;
    logic [32:0]     r_out;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [4:0]      w_base;
    logic [CHUNK:0]  w_sub;
    logic [31:0]     w_work_nxt;
    logic [31:0]     w_diff_final;
    logic            w_last;

    // Bit offset of the chunk handled this cycle.
    assign w_base = 5'(int'(r_cnt) * CHUNK);

    // One extra bit on the left: a negative chunk result wraps so that bit CHUNK is the borrow out.
    assign w_sub = {1'b0, r_a[w_base +: CHUNK]}
                 - {1'b0, r_b[w_base +: CHUNK]}
                 - {{CHUNK{1'b0}}, r_borrow};

    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        w_work_nxt = r_work;
        w_work_nxt[w_base +: CHUNK] = w_sub[CHUNK-1:0];
    end

`ifdef U_RCS32_ITER_SAT_EN
    assign w_diff_final = w_sub[CHUNK] ? 32'd0 : w_work_nxt;
`else
    assign w_diff_final = w_work_nxt;
`endif

    // The visible result lives in r_out, separate from the working register,
    // so partial chunks never show on the output and the last result is held in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_work      <= 32'd0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_out       <= 33'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_work   <= w_work_nxt;
                    r_borrow <= w_sub[CHUNK];
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_out       <= {w_sub[CHUNK], w_diff_final};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready         = r_in_ready;
    assign bus.out_valid        = r_out_valid;
    assign bus.u_rcs32_iter_out = r_out;
endmodule

// File: tb/tb_u_rcs32_iter.sv
// Purpose: self-checking bench for u_rcs32_iter (CHUNK=4 main instance, CHUNK=1 and 32 side instances).
// Latency: checks N-cycle result latency per instance.
// Backpressure: exercises held DONE under out_ready low and random consumer stalls.
module tb_u_rcs32_iter;
    localparam int N4 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    u_rcs32_iter_if if4 ();
    u_rcs32_iter_if if1 ();
    u_rcs32_iter_if if32 ();

    u_rcs32_iter #(.CHUNK(4))  dut     (.clk(clk), .rst(rst), .bus(if4));
    u_rcs32_iter #(.CHUNK(1))  dut_c1  (.clk(clk), .rst(rst), .bus(if1));
    u_rcs32_iter #(.CHUNK(32)) dut_c32 (.clk(clk), .rst(rst), .bus(if32));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Expected result straight from the arithmetic definition.
    function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = {1'b0, a} - {1'b0, b};
`ifdef U_RCS32_ITER_SAT_EN
        if (r[32]) r[31:0] = 32'd0;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Transaction-level model of the CHUNK=4 instance: -1 idle, >0 cycles of work left, 0 result pending.
    int          m_cnt = -1;
    logic [32:0] m_exp = 33'd0;
    logic [32:0] m_last = 33'd0;
    int          m_dlv = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_in_ready", if4.in_ready, 1'b1);
            chk1("rst_out_valid", if4.out_valid, 1'b0);
            chk("rst_out", if4.u_rcs32_iter_out, 33'd0);
            m_cnt  = -1;
            m_last = 33'd0;
        end else begin
            chk1("m_in_ready", if4.in_ready, m_cnt == -1);
            chk1("m_out_valid", if4.out_valid, m_cnt == 0);
            if (m_cnt == 0)
                chk("m_out_done", if4.u_rcs32_iter_out, m_exp);
            else if (m_cnt == -1)
                chk("m_out_idle_hold", if4.u_rcs32_iter_out, m_last);
            // Effect of the coming rising edge.
            if (m_cnt == -1) begin
                if (if4.in_valid) begin
                    m_exp = ref_sub(if4.a, if4.b);
                    m_cnt = N4;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else if (if4.out_ready) begin
                m_last = m_exp;
                m_cnt  = -1;
                m_dlv++;
            end
        end
    end

    // Present operands on the main instance until accepted; returns the acceptance cycle.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
        logic acc_now;
        bit   acc;
        acc = 0;
        if4.a = a;
        if4.b = b;
        if4.in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc_now = if4.in_ready;
            @(posedge clk);
            #1;
            if (acc_now) acc = 1;
        end
        if4.in_valid = 1'b0;
        acc_cyc = cyc;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_valid(output int seen_cyc);
        bit seen;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (if4.out_valid) seen = 1;
        end
        seen_cyc = cyc;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout actual=no_out_valid required=out_valid");
        end
    endtask

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp);
        int k, s;
        if4.out_ready = 1'b1;
        send(a, b, k);
        wait_valid(s);
        chki({nm, "_latency"}, s - k, N4);
        chk(nm, if4.u_rcs32_iter_out, exp);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1({nm, "_one_cycle"}, if4.out_valid, 1'b0);
        chk1({nm, "_ready_back"}, if4.in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Same operands to all three widths at once; side instances checked for value and latency.
    task automatic multi(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp);
        int k, s1, s32;
        logic [32:0] v1, v32;
        s1 = -1000; s32 = -1000; v1 = 33'd0; v32 = 33'd0;
        if4.out_ready = 1'b1; if1.out_ready = 1'b1; if32.out_ready = 1'b1;
        if4.a = a;  if4.b = b;  if1.a = a;  if1.b = b;  if32.a = a;  if32.b = b;
        if4.in_valid = 1'b1; if1.in_valid = 1'b1; if32.in_valid = 1'b1;
        @(negedge clk);
        chk1({nm, "_all_idle"}, if1.in_ready & if32.in_ready & if4.in_ready, 1'b1);
        @(posedge clk);
        #1;
        k = cyc;
        if4.in_valid = 1'b0; if1.in_valid = 1'b0; if32.in_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (if1.out_valid && s1 < 0)  begin s1 = cyc;  v1 = if1.u_rcs32_iter_out;  end
            if (if32.out_valid && s32 < 0) begin s32 = cyc; v32 = if32.u_rcs32_iter_out; end
        end
        chki({nm, "_c1_latency"}, s1 - k, 32);
        chk({nm, "_c1"}, v1, exp);
        chki({nm, "_c32_latency"}, s32 - k, 1);
        chk({nm, "_c32"}, v32, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s, base;
        logic [32:0] held;
        logic [31:0] ra, rb;
        if4.in_valid = 1'b0; if4.a = 32'd0; if4.b = 32'd0; if4.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = 32'd0; if1.b = 32'd0; if1.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.a = 32'd0; if32.b = 32'd0; if32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic values, hand-computed.
        do_op("sub_5_3", 32'd5, 32'd3, 33'h0_00000002);
`ifdef U_RCS32_ITER_SAT_EN
        do_op("sub_3_5", 32'd3, 32'd5, 33'h1_00000000);
        do_op("sub_0_1", 32'd0, 32'd1, 33'h1_00000000);
`else
        do_op("sub_3_5", 32'd3, 32'd5, 33'h1_FFFFFFFE);
        do_op("sub_0_1", 32'd0, 32'd1, 33'h1_FFFFFFFF);
`endif
        do_op("xchunk", 32'h0001_0000, 32'd1, 33'h0_0000FFFF);
        do_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_00000000);

        // Cross-chunk borrow on all three widths.
        multi("m_xchunk", 32'h0001_0000, 32'd1, 33'h0_0000FFFF);
        multi("m_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_00000000);
`ifdef U_RCS32_ITER_SAT_EN
        multi("m_3_5", 32'd3, 32'd5, 33'h1_00000000);
`else
        multi("m_3_5", 32'd3, 32'd5, 33'h1_FFFFFFFE);
`endif
        multi("m_big", 32'h8000_0000, 32'h0000_0001, 33'h0_7FFFFFFF);

        // Backpressure: DONE held with stable data, new operands ignored.
        if4.out_ready = 1'b0;
        send(32'h0000_0100, 32'h0000_0001, k);
        wait_valid(s);
        chk("bp_value", if4.u_rcs32_iter_out, 33'h0_000000FF);
        held = if4.u_rcs32_iter_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if4.in_valid = 1'b1;
            if4.a = 32'h1234_0000 + 32'(i);
            if4.b = 32'd7;
            @(negedge clk);
            chk1("bp_valid_held", if4.out_valid, 1'b1);
            chk("bp_data_stable", if4.u_rcs32_iter_out, held);
            chk1("bp_in_ready_low", if4.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("bp_release_ready", if4.in_ready, 1'b1);
        chk1("bp_release_valid", if4.out_valid, 1'b0);
        chk("bp_idle_hold", if4.u_rcs32_iter_out, 33'h0_000000FF);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN.
        send(32'h1234_5678, 32'h0000_1111, k);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk1("mid_rst_out_valid", if4.out_valid, 1'b0);
        chk("mid_rst_out", if4.u_rcs32_iter_out, 33'd0);
        chk1("mid_rst_in_ready", if4.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op("after_rst", 32'd10, 32'd4, 33'h0_00000006);

        // Back-to-back random traffic with a randomly stalling consumer.
        base = m_dlv;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    ra = $urandom;
                    rb = (i % 4 == 0) ? ra : $urandom;
                    send(ra, rb, k);
                end
            end
            begin
                for (int t = 0; t < 6000 && m_dlv < base + 100; t++) begin
                    @(posedge clk);
                    #1;
                    if4.out_ready = 1'($urandom_range(0, 1));
                end
                if4.out_ready = 1'b1;
            end
        join
        chki("rand_delivered", m_dlv - base, 100);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/u_rcs32_iter.md
# u_rcs32_iter

Iterative unsigned 32-bit ripple-borrow subtractor. It accepts an operand pair over a valid/ready handshake and computes `a - b` CHUNK bits per cycle, holding the inter-chunk borrow in a register. It returns a 33-bit result over a second valid/ready handshake. It sits in the arithmetic datapath next to the combinational 32-bit ripple-carry adder, trading latency for a narrow CHUNK-bit borrow chain.

## Interface
- CHUNK, default 4: bits processed per RUN cycle; must divide 32 (legal values 1, 2, 4, 8, 16, 32); N = 32/CHUNK.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  32  minuend, unsigned.
- b  input  32  subtrahend, unsigned.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- u_rcs32_iter_out  output  33  bits [31:0] are the difference; bit [32] is the final borrow (1 iff a < b).

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear borrow and chunk counter, go to RUN.
  - RUN: each cycle, for chunk index i (counter value), compute {bo, d} = a[i*CHUNK+:CHUNK] - b[i*CHUNK+:CHUNK] - borrow.
    - Write d into result bits [i*CHUNK+:CHUNK].
    - Set borrow to bo.
    - Increment the counter.
    - When i = N-1, go to DONE.
  - DONE: out_valid=1. Set result[32] to the final borrow. Hold until out_ready, then go to IDLE.
- Arithmetic: diff = (a - b) mod 2^32; bit 32 = borrow out of bit 31. No other widths are involved.
- Operand registers are captured only at acceptance. Input changes during RUN or DONE have no effect.
- in_valid in RUN or DONE is ignored. The source must hold it until in_ready.
- u_rcs32_iter_out is held stable throughout DONE, and keeps its last value in IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, u_rcs32_iter_out=0, borrow=0, counter=0.
- Latency: operands accepted at edge k; out_valid rises after edge k+N (N=8 for CHUNK=4). CHUNK=32 gives 1 RUN cycle.
- Result handshake completes at the first edge with out_valid&&out_ready. out_valid falls and in_ready rises after that edge.
- Throughput: one operation per N+2 cycles at best (accept, N RUN cycles, DONE).
- Boundary conditions:
  - out_ready high on entry to DONE: result is visible for exactly one cycle.
  - out_ready low: DONE is held indefinitely with stable data.
  - Counter wraps to 0 on leaving RUN.
  - rst in RUN or DONE aborts the operation immediately. The partial result is discarded and all outputs return to their reset values asynchronously.
  - rst released: IDLE accepts operands on the first edge after release.

## Configuration
- U_RCS32_ITER_SAT_EN defined: saturating subtract. When the final borrow is 1, bits [31:0] are forced to 0 in DONE, and bit [32] still reports 1.
- Not defined: bits [31:0] hold the wrapped modulo-2^32 difference.
- Latency and handshakes are identical in both builds.

## Test plan
- a=5, b=3, out_ready=1 -> out=0x0_00000002; out_valid exactly N cycles after accept, high for 1 cycle.
- a=3, b=5 -> out=0x1_FFFFFFFE (with U_RCS32_ITER_SAT_EN: 0x1_00000000); a=0, b=1 -> 0x1_FFFFFFFF.
- Cross-chunk borrow: a=0x00010000, b=1 -> 0x0_0000FFFF. Also a=b=0xFFFFFFFF -> 0x0_00000000. Repeat for CHUNK=1, 4 and 32.
- Backpressure: hold out_ready low 5 cycles in DONE -> out_valid and data stable, in_ready=0, and a new in_valid is not accepted. Release -> in_ready=1 the next cycle.
- Reset mid-RUN: assert rst at RUN cycle 3 -> out_valid=0, out=0 and in_ready=1 immediately. A fresh a=10, b=4 then yields 0x0_00000006.
- Back-to-back: 100 random pairs with random out_ready -> every result equals {a<b, (a-b) mod 2^32} (saturated per macro), in order, with none dropped or duplicated.
